// File: rtl/escritor_disparo.sv
// Applies one shot to a fleet memory: scans 12 words, clears the first matching slot, writes it back.
// Optional macro ESCRITOR_SUNK_EN enables the sunk flag; when undefined, sunk is tied low.
module escritor_disparo (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        player,
   input  logic [7:0]  coord,
   input  logic [63:0] memoriaP1,
   input  logic [63:0] memoriaP2,
   output logic [4:0]  addr,
   output logic        we_p1,
   output logic        we_p2,
   output logic [63:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        hit,
   output logic        sunk
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [4:0] LAST_ADDR = 5'd11;

   logic [2:0]  state_q,  state_d;
   logic        player_q, player_d;
   logic [7:0]  coord_q,  coord_d;
   logic [4:0]  addr_q,   addr_d;
   logic        we_p1_q,  we_p1_d;
   logic        we_p2_q,  we_p2_d;
   logic [63:0] wdata_q,  wdata_d;
   logic        busy_q,   busy_d;
   logic        done_q,   done_d;
   logic        hit_q,    hit_d;
   logic        sunk_q,   sunk_d;

   logic [63:0] rdata;
   logic [4:0]  slot_match;
   logic        any_match;
   logic [63:0] clr_word;
   logic        sunk_calc;

   assign rdata = player_q ? memoriaP2 : memoriaP1;

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_slot
         assign slot_match[gi] = (rdata[3+8*gi +: 8] == coord_q);
      end
   endgenerate

   assign any_match = |slot_match;

   // Only the lowest-index matching slot is zeroed; everything else passes through.
   always_comb begin
      clr_word = rdata;
      for (int i = 4; i >= 0; i--) begin
         if (slot_match[i]) begin
            clr_word = rdata;
            clr_word[3+8*i +: 8] = 8'h00;
         end
      end
   end

`ifdef ESCRITOR_SUNK_EN
   assign sunk_calc = (clr_word[42:3] == 40'd0);
`else
   assign sunk_calc = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      player_d = player_q;
      coord_d  = coord_q;
      addr_d   = addr_q;
      we_p1_d  = 1'b0;
      we_p2_d  = 1'b0;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hit_d    = hit_q;
      sunk_d   = sunk_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               player_d = player;
               coord_d  = coord;
               hit_d    = 1'b0;
               sunk_d   = 1'b0;
               busy_d   = 1'b1;
               if (coord == 8'h00) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = 5'd0;
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (any_match) begin
               wdata_d = clr_word;
               hit_d   = 1'b1;
               sunk_d  = sunk_calc;
               we_p1_d = ~player_q;
               we_p2_d = player_q;
               state_d = S_WRITE;
            end else if (addr_q < LAST_ADDR) begin
               addr_d  = addr_q + 5'd1;
               state_d = S_READ;
            end else begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_WRITE: begin
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            // An invalid shot arrives here without a pending pulse and issues it one cycle later.
            if (done_q) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         player_q <= 1'b0;
         coord_q  <= 8'h00;
         addr_q   <= 5'd0;
         we_p1_q  <= 1'b0;
         we_p2_q  <= 1'b0;
         wdata_q  <= 64'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
         sunk_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         coord_q  <= coord_d;
         addr_q   <= addr_d;
         we_p1_q  <= we_p1_d;
         we_p2_q  <= we_p2_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hit_q    <= hit_d;
         sunk_q   <= sunk_d;
      end
   end

   assign addr  = addr_q;
   assign we_p1 = we_p1_q;
   assign we_p2 = we_p2_q;
   assign wdata = wdata_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign hit   = hit_q;
   assign sunk  = sunk_q;

endmodule

// File: tb/tb_escritor_disparo.sv
// Directed bench for escritor_disparo with two synchronous-read fleet memories and a result scoreboard.
module tb_escritor_disparo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        player = 1'b0;
   logic [7:0]  coord = 8'h00;
   logic [63:0] memoriaP1, memoriaP2;
   logic [4:0]  addr;
   logic        we_p1, we_p2;
   logic [63:0] wdata;
   logic        busy, done, hit, sunk;

   escritor_disparo dut (
      .clk(clk), .rst_n(rst_n), .start(start), .player(player), .coord(coord),
      .memoriaP1(memoriaP1), .memoriaP2(memoriaP2), .addr(addr),
      .we_p1(we_p1), .we_p2(we_p2), .wdata(wdata), .busy(busy),
      .done(done), .hit(hit), .sunk(sunk)
   );

   always #5 clk = ~clk;

   // Fleet memories: 1-cycle read latency, write on the edge after the enable.
   logic [63:0] mem1 [12];
   logic [63:0] mem2 [12];
   logic        ld_en = 1'b0, ld_p = 1'b0;
   logic [3:0]  ld_a = 4'd0;
   logic [63:0] ld_d = 64'd0;
   wire  [3:0]  ai = (addr < 5'd12) ? addr[3:0] : 4'd0;

   always @(posedge clk) begin
      if (ld_en) begin
         if (ld_p) mem2[ld_a] <= ld_d;
         else      mem1[ld_a] <= ld_d;
      end
      if (we_p1 && addr < 5'd12) mem1[ai] <= wdata;
      if (we_p2 && addr < 5'd12) mem2[ai] <= wdata;
      memoriaP1 <= mem1[ai];
      memoriaP2 <= mem2[ai];
   end

   typedef struct {
      int          done_edge;
      logic        hit;
      logic        sunk;
      int          wr;
      int          wr_edge;
      logic [4:0]  wr_addr;
      logic [63:0] wr_data;
      logic        wr_p;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] sh1 [12];
   logic [63:0] sh2 [12];
   int          n_assert = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [20:0] hi, input logic [39:0] sl, input logic [2:0] lo);
      return {hi, sl, lo};
   endfunction

   // Reference model of one shot against the shadow fleets.
   function automatic exp_t predict(input logic p, input logic [7:0] c);
      exp_t        e;
      logic [63:0] w;
      e.done_edge = 24; e.hit = 1'b0; e.sunk = 1'b0; e.wr = 0;
      e.wr_edge = 0; e.wr_addr = 5'd0; e.wr_data = 64'd0; e.wr_p = p;
      if (c == 8'h00) begin
         e.done_edge = 1;
         return e;
      end
      for (int k = 0; k < 12; k++) begin
         w = p ? sh2[k] : sh1[k];
         for (int s = 0; s < 5; s++) begin
            if (w[3+8*s +: 8] == c) begin
               w[3+8*s +: 8] = 8'h00;
               e.hit = 1'b1;
`ifdef ESCRITOR_SUNK_EN
               e.sunk = (w[42:3] == 40'd0);
`endif
               e.wr = 1; e.wr_edge = 2*k + 2; e.wr_addr = 5'(k); e.wr_data = w;
               e.done_edge = 2*k + 3;
               if (p) sh2[k] = w; else sh1[k] = w;
               return e;
            end
         end
      end
      return e;
   endfunction

   task automatic load(input logic p, input int a, input logic [63:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_p = p; ld_a = 4'(a); ld_d = d;
      if (p) sh2[a] = d; else sh1[a] = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic run_shot(input string tag, input logic p, input logic [7:0] c, input int restart_edge);
      exp_t        e, got;
      int          done_edge = -1, nwr = 0, wr_edge = -1, both = 0, addr_bad = 0, busy_bad = 0, lim;
      logic [4:0]  wr_addr = 5'd0, addr_before;
      logic [63:0] wr_data = 64'd0;
      logic        wr_p = 1'b0;
      e = predict(p, c);
      sb.push_back(e);
      lim = e.wr ? 2 * int'(e.wr_addr) : 22;
      addr_before = addr;
      @(negedge clk);
      start = 1'b1; player = p; coord = c;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (n == restart_edge) begin
            @(negedge clk);
            start = 1'b1; player = ~p; coord = 8'h00;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (we_p1 && we_p2) both++;
         if (we_p1 || we_p2) begin
            nwr++; wr_edge = n; wr_addr = addr; wr_data = wdata; wr_p = we_p2;
         end
         if (!busy) busy_bad++;
         if (c == 8'h00 && addr != addr_before) addr_bad++;
         if (c != 8'h00 && n % 2 == 0 && n <= lim && int'(addr) != n / 2) addr_bad++;
         if (done) begin
            done_edge = n;
            break;
         end
      end
      got = sb.pop_front();
      chk({tag, " done_edge"}, 64'(done_edge), 64'(got.done_edge));
      chk({tag, " hit"}, 64'(hit), 64'(got.hit));
      chk({tag, " sunk"}, 64'(sunk), 64'(got.sunk));
      chk({tag, " write_count"}, 64'(nwr), 64'(got.wr));
      chk({tag, " both_we"}, 64'(both), 64'd0);
      chk({tag, " addr_seq"}, 64'(addr_bad), 64'd0);
      chk({tag, " busy_held"}, 64'(busy_bad), 64'd0);
      if (got.wr != 0 && nwr != 0) begin
         chk({tag, " wr_edge"}, 64'(wr_edge), 64'(got.wr_edge));
         chk({tag, " wr_addr"}, 64'(wr_addr), 64'(got.wr_addr));
         chk({tag, " wdata"}, wr_data, got.wr_data);
         chk({tag, " wr_player"}, 64'(wr_p), 64'(got.wr_p));
      end
      @(posedge clk); #1;
      chk({tag, " busy_after"}, 64'(busy), 64'd0);
      chk({tag, " done_once"}, 64'(done), 64'd0);
      chk({tag, " hit_held"}, 64'(hit), 64'(got.hit));
      $display("shot %s player=%0d coord=%02h done_edge=%0d hit=%0d sunk=%0d writes=%0d",
               tag, p, c, done_edge, hit, sunk, nwr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen_we;
      #12;
      chk("rst addr", 64'(addr), 64'd0);
      chk("rst we_p1", 64'(we_p1), 64'd0);
      chk("rst we_p2", 64'(we_p2), 64'd0);
      chk("rst wdata", wdata, 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst hit", 64'(hit), 64'd0);
      chk("rst sunk", 64'(sunk), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 12; k++) begin
         load(1'b0, k, mk(21'h15A5A + 21'(k), 40'd0, 3'(k)));
         load(1'b1, k, mk(21'h0C3C3 + 21'(k), 40'd0, 3'(7 - k)));
      end
      load(1'b1, 3, mk(21'h0ABCD, 40'h0000002524, 3'b101));
      load(1'b0, 0, mk(21'h1F00F, 40'h0031003100, 3'b011));
      load(1'b0, 5, mk(21'h01234, 40'h4712000000, 3'b110));
      load(1'b1, 6, mk(21'h1ACE1, 40'h0000660000, 3'b001));

      run_shot("hit_p2", 1'b1, 8'h25, 0);
      chk("hit_p2 mem word", mem2[3], mk(21'h0ABCD, 40'h0000000024, 3'b101));
      run_shot("sunk_p2", 1'b1, 8'h24, 0);
      chk("sunk_p2 mem slots", 64'(mem2[3][42:3]), 64'd0);
      run_shot("miss_p1", 1'b0, 8'h99, 0);
      run_shot("invalid", 1'b0, 8'h00, 0);
      run_shot("dup_p1", 1'b0, 8'h31, 0);
      chk("dup_p1 mem slots", 64'(mem1[0][42:3]), 64'h0031000000);
      run_shot("busy_start", 1'b0, 8'h47, 5);

      // Reset asserted just after edge 7 of a shot aimed at P2 word 6.
      seen_we = 0;
      @(negedge clk);
      start = 1'b1; player = 1'b1; coord = 8'h66;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         @(posedge clk); #1;
         if (we_p1 || we_p2) seen_we++;
      end
      #1 rst_n = 1'b0;
      #1;
      chk("midrst addr", 64'(addr), 64'd0);
      chk("midrst we_p2", 64'(we_p2), 64'd0);
      chk("midrst wdata", wdata, 64'd0);
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst done", 64'(done), 64'd0);
      chk("midrst hit", 64'(hit), 64'd0);
      chk("midrst sunk", 64'(sunk), 64'd0);
      chk("midrst no_write", 64'(seen_we), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst mem word6", mem2[6], mk(21'h1ACE1, 40'h0000660000, 3'b001));
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset mid-scan applied at edge 7, writes_seen=%0d", seen_we);

      run_shot("after_rst", 1'b1, 8'h66, 0);

      for (int k = 0; k < 12; k++) begin
         chk($sformatf("final mem1[%0d]", k), mem1[k], sh1[k]);
         chk($sformatf("final mem2[%0d]", k), mem2[k], sh2[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/escritor_disparo.md
# escritor_disparo

Applies one shot to a player's fleet memory. On `start` it scans the target player's 12 fleet words (addresses 0–11). If a coordinate slot equals the shot, it clears that slot and writes the word back, reporting hit and sunk. It is the write side of the fleet memory and runs between turns, before `ContagemPecas` recounts remaining ships.

## Interface
- No parameters.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request. Honoured only when `busy`=0.
- `player` input 1: target fleet. 0 = P1 memory, 1 = P2 memory. Captured on `start`.
- `coord` input 8: shot `{row[7:4], col[3:0]}`. Captured on `start`. 8'h00 is invalid.
- `memoriaP1` input 64: P1 read data. Synchronous read, 1-cycle latency from `addr`.
- `memoriaP2` input 64: P2 read data, same timing as `memoriaP1`.
- `addr` output 5: shared read/write address, range 0–11.
- `we_p1` output 1: P1 write enable. Write occurs on the next rising edge.
- `we_p2` output 1: P2 write enable. Write occurs on the next rising edge.
- `wdata` output 64: write-back word.
- `busy` output 1: high from the cycle after `start` through the `done` cycle.
- `done` output 1: one-cycle completion pulse.
- `hit` output 1: result of the last shot. Valid from `done`, held until the next accepted `start`.
- `sunk` output 1: the hit emptied the word. Same validity as `hit`.

## Operation
- Word format:
  - bits [42:3] hold five 8-bit slots; slot i is bits [10+8i : 3+8i].
  - A slot value of 0 means empty or already hit.
  - Bits [63:43] and [2:0] are opaque and always written back unchanged.
- States: IDLE, READ, CHECK, WRITE, DONE.
- IDLE
  - With `start`=1: capture `player` and `coord`, clear `hit`/`sunk`, set `addr`=0, go to READ.
  - If `coord`=0: go directly to DONE with `hit`=0; no memory access.
- READ: wait state for read latency → CHECK.
- CHECK: compare `coord` with all five slots of the selected read data.
  - Match: `wdata` = read word with the lowest-index matching slot zeroed. Set `hit`=1. `sunk` = (`wdata[42:3]`==0). Go to WRITE.
  - No match, `addr`<11: `addr`+1, go to READ.
  - No match, `addr`=11: `hit`=0, go to DONE.
- WRITE: assert `we_p1` or `we_p2` (per captured `player`) for exactly one cycle, with `addr`/`wdata` stable → DONE.
- DONE: `done`=1 for one cycle → IDLE. `busy` drops on the same edge that leaves DONE.
- At most one slot is cleared per shot; the scan stops at the first matching word.
- Already-empty slots never match, because `coord`≠0.
- `start` while `busy`=1 is ignored; there is no queueing.
- `we_p1` and `we_p2` are never high together, and never high outside WRITE.
- Reset mid-operation: immediately IDLE, write enables low, no partial write.

## Timing
- Reset values:
  - `addr`=0, `we_p1`=0, `we_p2`=0, `wdata`=0
  - `busy`=0, `done`=0, `hit`=0, `sunk`=0
  - state IDLE
- Edge 0 samples `start`. The word at address k is checked in the cycle after edge 2k+1.
- Hit in word k:
  - write enable high in the cycle after edge 2k+2;
  - `done` high in the cycle after edge 2k+3.
- Full miss: `done` high in the cycle after edge 24.
- `coord`=0: `done` high in the cycle after edge 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ESCRITOR_SUNK_EN`
  - Defined: `sunk` is computed as above.
  - Undefined: `sunk` is tied to 0 and its compare logic is removed. `hit`, writes and timing are unchanged.

## Test plan
- Hit, not sunk:
  - Setup: P2 addr 3 `[42:3]`=40'h0000002524, `[2:0]`=3'b101; other P2 words empty.
  - Stimulus: `start`, `player`=1, `coord`=8'h25.
  - Required: `we_p2`=1 with `addr`=3 after edge 8; `wdata[42:3]`=40'h0000000024, `wdata[2:0]`=3'b101; `done` after edge 9 with `hit`=1, `sunk`=0; `we_p1` never high.
- Sunk: follow-up shot 8'h24 → word 3 `[42:3]` becomes 0; `hit`=1; `sunk`=1 with the macro defined, 0 without.
- Miss:
  - Stimulus: `coord`=8'h99 on any fleet.
  - Required: `addr` steps 0..11; no write enable; `done` after edge 24; `hit`=0.
- Duplicate and invalid coordinates:
  - Duplicate: 8'h31 in slots 1 and 3 of P1 addr 0 → only slot 1 cleared; `done` after edge 3.
  - Invalid: `coord`=8'h00 → `done` after edge 1; no `addr` change; `hit`=0.
- Start while busy: a second `start` at edge 5 of a scan is ignored; exactly one `done`.
- Reset mid-scan: `rst_n` low at edge 7 of a P2 shot that would hit word 6 → all outputs reset values immediately; no `we_p2`; memory unchanged.
